div_rem_sgn_seq: RTL and testbench



---
 rtl/lau_pkg.sv | 11 +
 rtl/div_rem_sgn_seq_if.sv | 28 ++
 rtl/div_step_unsgn.sv | 27 ++
 rtl/div_rem_sgn_seq.sv | 129 ++++++++++++
 tb/tb_div_rem_sgn_seq.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/lau_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding for the sequential divider.
package lau_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/div_rem_sgn_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
interface div_rem_sgn_seq_if #(
  parameter int widthN = 16,
  parameter int widthD = 8
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [widthN-1:0] N_i;
  logic [widthD-1:0] D_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [widthN-1:0] Q_o;
  logic [widthD-1:0] R_o;
  logic              dz_o;
  logic              ovf_o;

  modport master (
    output in_valid_i, N_i, D_i, out_ready_i,
    input  in_ready_o, out_valid_o, Q_o, R_o, dz_o, ovf_o
  );

  modport slave (
    input  in_valid_i, N_i, D_i, out_ready_i,
    output in_ready_o, out_valid_o, Q_o, R_o, dz_o, ovf_o
  );

endinterface

// File: rtl/div_step_unsgn.sv
// One restoring-division step on magnitudes: shift in a dividend bit, trial-subtract |D|.
module div_step_unsgn #(
  parameter int widthD = 8
) (
  input  logic [widthD:0] rem_i,
  input  logic            bit_i,
  input  logic [widthD:0] dmag_i,
  output logic [widthD:0] rem_o,
  output logic            q_o
);

  logic [widthD+1:0] trial;
  logic [widthD:0]   diff;

  assign trial = {rem_i, bit_i};
  assign diff  = trial[widthD:0] - dmag_i;

  always_comb begin
    rem_o = trial[widthD:0];
    q_o   = 1'b0;
    if (trial >= {1'b0, dmag_i}) begin
      rem_o = diff;
      q_o   = 1'b1;
    end
  end

endmodule

// File: rtl/div_rem_sgn_seq.sv
// Iterative signed divider, one quotient bit per cycle, truncating toward zero.
module div_rem_sgn_seq
  import lau_pkg::*;
#(
  parameter int widthN = 16,
  parameter int widthD = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  div_rem_sgn_seq_if.slave bus_io
);

  localparam int CW = (widthN > 1) ? $clog2(widthN) : 1;

  div_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic [widthN-1:0] qn_q;
  logic [widthD:0]   rem_q;
  logic [widthD:0]   dmag_q;
  logic [widthD-1:0] nlow_q;
  logic              sn_q, sd_q, dz_pend_q, ovf_pend_q;
  logic [widthN-1:0] q_q;
  logic [widthD-1:0] r_q;
  logic              dz_q, ovf_q;

  logic [widthN-1:0] nmag;
  logic [widthD:0]   d_ext, dmag;
  logic [widthD:0]   rem_d;
  logic              qbit_d;
  logic [widthN-1:0] q_fix;
  logic [widthD-1:0] r_fix;
  logic              is_min_n, is_m1_d;

  // |N| fits in widthN unsigned bits, including |-2^(widthN-1)| = 2^(widthN-1)
  assign nmag  = bus_io.N_i[widthN-1] ? (~bus_io.N_i + 1'b1) : bus_io.N_i;
  assign d_ext = {bus_io.D_i[widthD-1], bus_io.D_i};
  assign dmag  = bus_io.D_i[widthD-1] ? (~d_ext + 1'b1) : d_ext;

  assign is_min_n = (bus_io.N_i == {1'b1, {(widthN-1){1'b0}}});
  assign is_m1_d  = (bus_io.D_i == {widthD{1'b1}});

  div_step_unsgn #(.widthD(widthD)) u_step (
    .rem_i  (rem_q),
    .bit_i  (qn_q[widthN-1]),
    .dmag_i (dmag_q),
    .rem_o  (rem_d),
    .q_o    (qbit_d)
  );

  assign q_fix = (sn_q ^ sd_q) ? (~qn_q + 1'b1) : qn_q;
  assign r_fix = sn_q ? (~rem_q[widthD-1:0] + 1'b1) : rem_q[widthD-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      qn_q       <= '0;
      rem_q      <= '0;
      dmag_q     <= '0;
      nlow_q     <= '0;
      sn_q       <= 1'b0;
      sd_q       <= 1'b0;
      dz_pend_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (bus_io.in_valid_i) begin
            qn_q       <= nmag;
            rem_q      <= '0;
            dmag_q     <= dmag;
            nlow_q     <= bus_io.N_i[widthD-1:0];
            sn_q       <= bus_io.N_i[widthN-1];
            sd_q       <= bus_io.D_i[widthD-1];
            dz_pend_q  <= (bus_io.D_i == '0);
            ovf_pend_q <= is_min_n && is_m1_d;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= CW'(widthN - 1);
            state_q    <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          // quotient bits shift in behind the dividend bits being consumed
          rem_q <= rem_d;
          qn_q  <= {qn_q[widthN-2:0], qbit_d};
          if (cnt_q == '0) begin
            state_q <= DIV_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIV_FIX: begin
          if (dz_pend_q) begin
            q_q  <= '1;
            r_q  <= nlow_q;
            dz_q <= 1'b1;
          end else if (ovf_pend_q) begin
            q_q   <= {1'b1, {(widthN-1){1'b0}}};
            r_q   <= '0;
            ovf_q <= 1'b1;
          end else begin
            q_q <= q_fix;
            r_q <= r_fix;
          end
          state_q <= DIV_DONE;
        end
        DIV_DONE: begin
          if (bus_io.out_ready_i) begin
            state_q <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign bus_io.in_ready_o  = (state_q == DIV_IDLE);
  assign bus_io.out_valid_o = (state_q == DIV_DONE);
  assign bus_io.Q_o         = q_q;
  assign bus_io.R_o         = r_q;
  assign bus_io.dz_o        = dz_q;
  assign bus_io.ovf_o       = ovf_q;

endmodule

// File: tb/tb_div_rem_sgn_seq.sv
// Scoreboard bench for div_rem_sgn_seq with hand-computed directed vectors.
module tb_div_rem_sgn_seq;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  div_rem_sgn_seq_if #(.widthN(16), .widthD(8)) bus ();

  div_rem_sgn_seq #(.widthN(16), .widthD(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("Q", 32'(bus.Q_o), 32'(e.q));
        chk("R", 32'(bus.R_o), 32'(e.r));
        chk("dz", 32'(bus.dz_o), 32'(e.dz));
        chk("ovf", 32'(bus.ovf_o), 32'(e.ovf));
      end
    end
  end

  // Issue one operation, then return at the first negedge where out_valid_o is high.
  task automatic issue(input logic [15:0] n, input logic [7:0] d,
                       input logic [15:0] q, input logic [7:0] r,
                       input logic dz, input logic ovf);
    exp_t e;
    int   t;
    int   lat;
    t = 0;
    while (!bus.in_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
    bus.N_i        = n;
    bus.D_i        = d;
    bus.in_valid_i = 1'b1;
    e.q = q; e.r = r; e.dz = dz; e.ovf = ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.N_i        = 16'($urandom);
    bus.D_i        = 8'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid_o && lat < 40);
    chk("latency", 32'(lat), 32'd18);
  endtask

  initial begin
    int t;
    int seen;
    checks   = 0;
    failures = 0;
    rst            = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.N_i        = '0;
    bus.D_i        = '0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_Q", 32'(bus.Q_o), 32'd0);
    chk("rst_R", 32'(bus.R_o), 32'd0);
    chk("rst_dz", 32'(bus.dz_o), 32'd0);
    chk("rst_ovf", 32'(bus.ovf_o), 32'd0);
    rst = 1'b0;

    issue(16'd100,  8'd7,   16'h000E, 8'h02, 1'b0, 1'b0);
    issue(16'hFF9C, 8'd7,   16'hFFF2, 8'hFE, 1'b0, 1'b0);
    issue(16'd100,  8'hF9,  16'hFFF2, 8'h02, 1'b0, 1'b0);
    issue(16'hFF9C, 8'hF9,  16'h000E, 8'hFE, 1'b0, 1'b0);
    issue(16'h04D2, 8'h00,  16'hFFFF, 8'hD2, 1'b1, 1'b0);
    issue(16'h8000, 8'hFF,  16'h8000, 8'h00, 1'b0, 1'b1);
    issue(16'd5,    8'd100, 16'h0000, 8'h05, 1'b0, 1'b0);
    issue(16'h8000, 8'h80,  16'h0100, 8'h00, 1'b0, 1'b0);

    // Backpressure: result must hold in DONE while new operands are offered
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    issue(16'h7FFF, 8'h80, 16'hFF01, 8'h7F, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.N_i        = 16'($urandom);
      bus.D_i        = 8'($urandom);
      bus.in_valid_i = 1'b1;
      @(negedge clk);
      chk("hold_Q", 32'(bus.Q_o), 32'h0000FF01);
      chk("hold_R", 32'(bus.R_o), 32'h0000007F);
      chk("hold_in_ready", 32'(bus.in_ready_o), 32'd0);
      chk("hold_out_valid", 32'(bus.out_valid_o), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("post_hs_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("post_hs_out_valid", 32'(bus.out_valid_o), 32'd0);

    // Reset in the 5th CALC cycle
    bus.N_i        = 16'd100;
    bus.D_i        = 8'd7;
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("midrst_Q", 32'(bus.Q_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid_o) seen = 1;
    end
    chk("midrst_no_spurious", 32'(seen), 32'd0);
    issue(16'hFFF9, 8'd2, 16'hFFFD, 8'hFF, 1'b0, 1'b0);

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
